spatz_strbreq_rmw_unit: RTL and testbench
=========================================

Name: spatz_strbreq_rmw_unit

Overview:
- Sits directly downstream of the partial-write merge tree, between the merged request port and the cache.
- Full-strobe writes and reads pass through unchanged.
- A write with an incomplete strobe becomes a read-modify-write: drain outstanding traffic, read the word, merge the strobed bytes, issue one full-strobe write.
- The cache therefore only ever sees full-word writes.

Parameters:
- DataWidth, 32, data width in bits; DataWidth/8 strobe bits.
- AddrWidth, 32, address width.
- UserWidth, 8, opaque user/req_id field, returned unchanged with responses.
- MaxOutstanding, 16, maximum in-flight downstream requests awaiting an upstream response.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- in_q_valid_i  in  1  upstream request valid.
- in_q_ready_o  out  1  upstream request accepted.
- in_q_addr_i  in  AddrWidth  request address.
- in_q_write_i  in  1  1 = write.
- in_q_strb_i  in  DataWidth/8  byte strobe.
- in_q_data_i  in  DataWidth  write data.
- in_q_user_i  in  UserWidth  user field.
- in_p_valid_o  out  1  upstream response valid.
- in_p_ready_i  in  1  upstream response ready.
- in_p_data_o  out  DataWidth  response data.
- in_p_write_o  out  1  response belongs to a write.
- in_p_user_o  out  UserWidth  response user.
- out_q_valid_o, out_q_ready_i, out_q_addr_o, out_q_write_o, out_q_strb_o, out_q_data_o, out_q_user_o: cache-side request, same widths and meanings as the upstream request.
- out_p_valid_i, out_p_ready_o, out_p_data_i, out_p_write_i, out_p_user_i: cache-side response, same widths and meanings as the upstream response.

Behaviour:
- Partial write: in_q_valid_i & in_q_write_i & (in_q_strb_i != all ones). An all-zero strobe counts as partial; the same data is written back.
- Registers:
  - state (IDLE, DRAIN, RD_REQ, RD_WAIT, WR_REQ).
  - cnt, $clog2(MaxOutstanding+1) bits.
  - captured addr, strb, data, user.
  - merged data.
  - rst_i clears all of them to 0 and state to IDLE immediately, including mid-RMW; any in-flight transaction is abandoned.
- Reset output values: out_q_valid_o=0, in_p_valid_o=0, in_q_ready_o=0 (in_q_valid_i is 0 at reset).
- Counter (cnt):
  - +1 on every downstream request handshake that expects a forwarded response (passthrough and RMW write).
  - −1 on every upstream response handshake.
  - Both in the same cycle: unchanged.
  - Never exceeds MaxOutstanding.
- IDLE, passthrough:
  - out_q_* = in_q_*, combinationally.
  - out_q_valid_o = in_q_valid_i & (cnt < MaxOutstanding).
  - in_q_ready_o = out_q_ready_i & (cnt < MaxOutstanding).
- IDLE, partial write:
  - out_q_valid_o=0, in_q_ready_o=1.
  - Capture addr/strb/data/user; go to DRAIN.
- DRAIN: in_q_ready_o=0; go to RD_REQ when cnt==0, evaluated on the registered value (minimum one cycle in DRAIN).
- RD_REQ:
  - out_q_valid_o=1, write=0, addr=captured, user=captured, strb all ones.
  - On out_q_ready_i go to RD_WAIT. cnt is not incremented.
- RD_WAIT:
  - out_p_ready_o=1 and in_p_valid_o=0; the read response is absorbed, not forwarded.
  - On out_p_valid_i: merged[byte i] = captured strb[i] ? captured data : out_p_data_i; go to WR_REQ.
- WR_REQ:
  - out_q_valid_o=1, write=1, strb all ones, data=merged, addr/user=captured.
  - On out_q_ready_i: cnt+1, go to IDLE. The next upstream request can be accepted the following cycle.
- Response path in all states except RD_WAIT: in_p_* = out_p_*, out_p_ready_o = in_p_ready_i, combinational.
- Ordering:
  - Drain guarantees the only outstanding response in RD_WAIT is the RMW read.
  - Upstream order is preserved because no request is accepted during DRAIN through WR_REQ.
- Minimum RMW latency with a zero-wait cache:
  - Accept at T.
  - DRAIN at T+1, read issued at T+2.
  - Read response at T+3 or later; write issued the next cycle.
- Valid/ready: the block holds out_q_* stable while out_q_valid_o=1 and out_q_ready_i=0 (registered states). In IDLE passthrough, stability is inherited from upstream.

Test Plan:
- Read addr 0x100, user 0x05, cache ready -> forwarded same cycle; response data 0xDEADBEEF returned with user 0x05; cnt 0→1→0.
- Write strb 0x3, data 0x0000AAAA, addr 0x40; cache read returns 0x12345678 -> single cache write strb 0xF, data 0x1234AAAA, user preserved; upstream sees exactly one write response.
- Three reads outstanding, then a partial write -> held in DRAIN until all three responses handshake; read issued only after cnt==0; no upstream request accepted meanwhile.
- cnt==MaxOutstanding=16 -> in_q_ready_o=0 and out_q_valid_o=0 until one response handshakes; simultaneous request and response keeps cnt at 16.
- Strb 0x0 write -> RMW writes back the read data unchanged, strb 0xF; strb 0xF write -> pure passthrough, no read issued.
- Assert rst_i during RD_WAIT -> next cycle state IDLE, cnt 0, out_q_valid_o=0; the late read response is not forwarded as valid if it coincides with reset.

Source files
------------

// File: rtl/spatz_strbreq_rmw_unit.sv
// Strobe-completion unit: passes full-strobe traffic through and turns partial
// writes into drain / read / merge / full-strobe write sequences.
module spatz_strbreq_rmw_unit #(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned UserWidth      = 8,
  parameter int unsigned MaxOutstanding = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_q_valid_i,
  output logic                   in_q_ready_o,
  input  logic [AddrWidth-1:0]   in_q_addr_i,
  input  logic                   in_q_write_i,
  input  logic [DataWidth/8-1:0] in_q_strb_i,
  input  logic [DataWidth-1:0]   in_q_data_i,
  input  logic [UserWidth-1:0]   in_q_user_i,
  output logic                   in_p_valid_o,
  input  logic                   in_p_ready_i,
  output logic [DataWidth-1:0]   in_p_data_o,
  output logic                   in_p_write_o,
  output logic [UserWidth-1:0]   in_p_user_o,
  output logic                   out_q_valid_o,
  input  logic                   out_q_ready_i,
  output logic [AddrWidth-1:0]   out_q_addr_o,
  output logic                   out_q_write_o,
  output logic [DataWidth/8-1:0] out_q_strb_o,
  output logic [DataWidth-1:0]   out_q_data_o,
  output logic [UserWidth-1:0]   out_q_user_o,
  input  logic                   out_p_valid_i,
  output logic                   out_p_ready_o,
  input  logic [DataWidth-1:0]   out_p_data_i,
  input  logic                   out_p_write_i,
  input  logic [UserWidth-1:0]   out_p_user_i
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned CntWidth  = $clog2(MaxOutstanding + 1);

  typedef enum logic [2:0] {IDLE, DRAIN, RD_REQ, RD_WAIT, WR_REQ} state_e;

  state_e                 r_state, w_state_n;
  logic [CntWidth-1:0]    r_cnt;
  logic [AddrWidth-1:0]   r_addr;
  logic [StrbWidth-1:0]   r_strb;
  logic [DataWidth-1:0]   r_data;
  logic [UserWidth-1:0]   r_user;
  logic [DataWidth-1:0]   r_merged;
  logic [DataWidth-1:0]   w_merged;
  logic                   w_partial, w_room, w_cap, w_merge_en, w_inc, w_dec;

  assign w_partial = in_q_valid_i & in_q_write_i & (in_q_strb_i != '1);
  assign w_room    = r_cnt < CntWidth'(MaxOutstanding);

  // Strobed bytes come from the captured write, the rest from the cache read.
  always_comb begin
    w_merged = '0;
    for (int i = 0; i < int'(StrbWidth); i++) begin
      w_merged[i*8 +: 8] = r_strb[i] ? r_data[i*8 +: 8] : out_p_data_i[i*8 +: 8];
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_cap         = 1'b0;
    w_merge_en    = 1'b0;
    in_q_ready_o  = 1'b0;
    out_q_valid_o = 1'b0;
    out_q_addr_o  = in_q_addr_i;
    out_q_write_o = in_q_write_i;
    out_q_strb_o  = in_q_strb_i;
    out_q_data_o  = in_q_data_i;
    out_q_user_o  = in_q_user_i;
    in_p_valid_o  = out_p_valid_i;
    in_p_data_o   = out_p_data_i;
    in_p_write_o  = out_p_write_i;
    in_p_user_o   = out_p_user_i;
    out_p_ready_o = in_p_ready_i;
    case (r_state)
      IDLE: begin
        if (w_partial) begin
          in_q_ready_o = 1'b1;
          w_cap        = 1'b1;
          w_state_n    = DRAIN;
        end else begin
          out_q_valid_o = in_q_valid_i & w_room;
          in_q_ready_o  = out_q_ready_i & w_room;
        end
      end
      DRAIN: begin
        if (r_cnt == '0) w_state_n = RD_REQ;
      end
      RD_REQ: begin
        out_q_valid_o = 1'b1;
        out_q_addr_o  = r_addr;
        out_q_write_o = 1'b0;
        out_q_strb_o  = '1;
        out_q_data_o  = r_data;
        out_q_user_o  = r_user;
        if (out_q_ready_i) w_state_n = RD_WAIT;
      end
      RD_WAIT: begin
        out_p_ready_o = 1'b1;
        in_p_valid_o  = 1'b0;
        if (out_p_valid_i) begin
          w_merge_en = 1'b1;
          w_state_n  = WR_REQ;
        end
      end
      WR_REQ: begin
        out_q_valid_o = 1'b1;
        out_q_addr_o  = r_addr;
        out_q_write_o = 1'b1;
        out_q_strb_o  = '1;
        out_q_data_o  = r_merged;
        out_q_user_o  = r_user;
        if (out_q_ready_i) w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
    // Nothing handshakes while reset is held, including a late cache response.
    if (rst_i) begin
      in_q_ready_o  = 1'b0;
      out_q_valid_o = 1'b0;
      in_p_valid_o  = 1'b0;
    end
  end

  // The RMW read is absorbed internally, so it never counts as outstanding.
  assign w_inc = out_q_valid_o & out_q_ready_i & (r_state != RD_REQ);
  assign w_dec = in_p_valid_o & in_p_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_strb   <= '0;
      r_data   <= '0;
      r_user   <= '0;
      r_merged <= '0;
    end else begin
      r_state <= w_state_n;
      case ({w_inc, w_dec})
        2'b10:   r_cnt <= r_cnt + CntWidth'(1);
        2'b01:   r_cnt <= r_cnt - CntWidth'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_cap) begin
        r_addr <= in_q_addr_i;
        r_strb <= in_q_strb_i;
        r_data <= in_q_data_i;
        r_user <= in_q_user_i;
      end
      if (w_merge_en) r_merged <= w_merged;
    end
  end

endmodule

// File: tb/tb_spatz_strbreq_rmw_unit.sv
// Randomised bench: word-level memory model plus an in-order cache model with
// random stalls; responses and final memory contents checked against the model.
module tb_spatz_strbreq_rmw_unit;

  logic        clk, rst;
  logic        in_q_valid_i, in_q_ready_o, in_q_write_i;
  logic [31:0] in_q_addr_i, in_q_data_i;
  logic [3:0]  in_q_strb_i;
  logic [7:0]  in_q_user_i;
  logic        in_p_valid_o, in_p_ready_i, in_p_write_o;
  logic [31:0] in_p_data_o;
  logic [7:0]  in_p_user_o;
  logic        out_q_valid_o, out_q_ready_i, out_q_write_o;
  logic [31:0] out_q_addr_o, out_q_data_o;
  logic [3:0]  out_q_strb_o;
  logic [7:0]  out_q_user_o;
  logic        out_p_valid_i, out_p_ready_o, out_p_write_i;
  logic [31:0] out_p_data_i;
  logic [7:0]  out_p_user_i;

  spatz_strbreq_rmw_unit dut (
    .clk_i(clk), .rst_i(rst),
    .in_q_valid_i(in_q_valid_i), .in_q_ready_o(in_q_ready_o), .in_q_addr_i(in_q_addr_i),
    .in_q_write_i(in_q_write_i), .in_q_strb_i(in_q_strb_i), .in_q_data_i(in_q_data_i),
    .in_q_user_i(in_q_user_i),
    .in_p_valid_o(in_p_valid_o), .in_p_ready_i(in_p_ready_i), .in_p_data_o(in_p_data_o),
    .in_p_write_o(in_p_write_o), .in_p_user_o(in_p_user_o),
    .out_q_valid_o(out_q_valid_o), .out_q_ready_i(out_q_ready_i), .out_q_addr_o(out_q_addr_o),
    .out_q_write_o(out_q_write_o), .out_q_strb_o(out_q_strb_o), .out_q_data_o(out_q_data_o),
    .out_q_user_o(out_q_user_o),
    .out_p_valid_i(out_p_valid_i), .out_p_ready_o(out_p_ready_o), .out_p_data_i(out_p_data_i),
    .out_p_write_i(out_p_write_i), .out_p_user_i(out_p_user_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  strb;
    logic [31:0] data;
    logic [7:0]  user;
  } req_t;

  typedef struct {
    logic        write;
    logic [31:0] data;
    logic [7:0]  user;
  } rsp_t;

  int n_vec = 0;
  int n_err = 0;

  req_t        dir_q[$];
  rsp_t        exp_q[$];
  rsp_t        cache_q[$];
  logic [31:0] mem_c[logic [31:0]];
  logic [31:0] mem_r[logic [31:0]];
  bit          hold_resp = 0, rand_mode = 0, up_pending = 0, pres = 0;
  req_t        cur;
  int          n_up_acc = 0, n_c_rd = 0, n_c_wr = 0;
  logic [31:0] last_c_wr = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] rd_c(input logic [31:0] a);
    return mem_c.exists(a) ? mem_c[a] : init_word(a);
  endfunction

  function automatic logic [31:0] rd_r(input logic [31:0] a);
    return mem_r.exists(a) ? mem_r[a] : init_word(a);
  endfunction

  function automatic req_t mk_req(input logic [31:0] a, input logic w, input logic [3:0] s,
                                  input logic [31:0] d, input logic [7:0] u);
    req_t r;
    r.addr = a; r.write = w; r.strb = s; r.data = d; r.user = u;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.addr  = 32'($urandom_range(0, 15)) << 2;
    r.write = ($urandom_range(0, 1) == 1);
    r.strb  = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
    r.data  = $urandom;
    r.user  = 8'($urandom_range(0, 255));
    return r;
  endfunction

  // One clock: drive at posedge+1, settle, account handshakes at posedge+5.
  task automatic cycle();
    rsp_t  e;
    logic [31:0] old, m;
    if (!up_pending) begin
      if (dir_q.size() != 0) begin
        cur = dir_q.pop_front(); up_pending = 1;
      end else if (rand_mode && $urandom_range(0, 2) == 0) begin
        cur = rand_req(); up_pending = 1;
      end
    end
    in_q_valid_i  = up_pending;
    in_q_addr_i   = cur.addr;
    in_q_write_i  = cur.write;
    in_q_strb_i   = cur.strb;
    in_q_data_i   = cur.data;
    in_q_user_i   = cur.user;
    in_p_ready_i  = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    out_q_ready_i = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (!pres && !hold_resp && cache_q.size() != 0 && (!rand_mode || $urandom_range(0, 2) != 0))
      pres = 1;
    out_p_valid_i = pres;
    out_p_write_i = pres ? cache_q[0].write : 1'b0;
    out_p_data_i  = pres ? cache_q[0].data : '0;
    out_p_user_i  = pres ? cache_q[0].user : '0;
    #4;
    if (in_q_valid_i && in_q_ready_o) begin
      n_up_acc++;
      if (cur.write) begin
        old = rd_r(cur.addr);
        m   = old;
        for (int b = 0; b < 4; b++) if (cur.strb[b]) m[b*8 +: 8] = cur.data[b*8 +: 8];
        mem_r[cur.addr] = m;
        e.write = 1'b1; e.data = '0; e.user = cur.user;
      end else begin
        e.write = 1'b0; e.data = rd_r(cur.addr); e.user = cur.user;
      end
      exp_q.push_back(e);
      if (!(cur.write && cur.strb != 4'hF))
        check_eq("pass_fwd", {out_q_valid_o, out_q_ready_i, out_q_write_o, out_q_strb_o,
                              out_q_user_o, out_q_addr_o[15:0]},
                 {1'b1, 1'b1, cur.write, cur.strb, cur.user, cur.addr[15:0]});
      up_pending = 0;
    end
    if (out_q_valid_o && out_q_ready_i) begin
      if (out_q_write_o) begin
        check_eq("cache_wr_strb", 32'(out_q_strb_o), 32'hF);
        n_c_wr++;
        last_c_wr = out_q_data_o;
        mem_c[out_q_addr_o] = out_q_data_o;
        e.write = 1'b1; e.data = '0;
      end else begin
        n_c_rd++;
        e.write = 1'b0; e.data = rd_c(out_q_addr_o);
      end
      e.user = out_q_user_o;
      cache_q.push_back(e);
    end
    if (out_p_valid_i && out_p_ready_o) begin
      void'(cache_q.pop_front());
      pres = 0;
    end
    if (in_p_valid_o && in_p_ready_i) begin
      if (exp_q.size() == 0) begin
        check_eq("rsp_unexpected", 32'(in_p_user_o), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_eq("rsp_write", 32'(in_p_write_o), 32'(e.write));
        check_eq("rsp_user", 32'(in_p_user_o), 32'(e.user));
        check_eq("rsp_data", in_p_data_o, e.data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_idle();
    int k;
    for (k = 0; k < 3000; k++) begin
      if (!up_pending && dir_q.size() == 0 && exp_q.size() == 0 && cache_q.size() == 0) break;
      cycle();
    end
    if (k == 3000) check_eq("idle_timeout", 32'(exp_q.size()), 32'(0));
  endtask

  int a0, r0, w0, tries;

  initial begin
    cur = mk_req('0, 1'b0, 4'hF, '0, '0);
    rst = 1'b1;
    in_q_valid_i = 0; in_q_addr_i = '0; in_q_write_i = 0; in_q_strb_i = '0;
    in_q_data_i = '0; in_q_user_i = '0; in_p_ready_i = 1; out_q_ready_i = 1;
    out_p_valid_i = 1; out_p_data_i = 32'h1111_2222; out_p_write_i = 0; out_p_user_i = 8'h77;
    #2;
    check_eq("rst_in_q_ready", 32'(in_q_ready_o), 0);
    check_eq("rst_out_q_valid", 32'(out_q_valid_o), 0);
    check_eq("rst_in_p_valid", 32'(in_p_valid_o), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; out_p_valid_i = 0;

    // Plain read passthrough.
    mem_c[32'h100] = 32'hDEAD_BEEF; mem_r[32'h100] = 32'hDEAD_BEEF;
    dir_q.push_back(mk_req(32'h100, 1'b0, 4'hF, '0, 8'h05));
    run_idle();

    // Partial write merge.
    mem_c[32'h40] = 32'h1234_5678; mem_r[32'h40] = 32'h1234_5678;
    r0 = n_c_rd; w0 = n_c_wr;
    dir_q.push_back(mk_req(32'h40, 1'b1, 4'h3, 32'h0000_AAAA, 8'h3C));
    run_idle();
    check_eq("rmw_wr_data", last_c_wr, 32'h1234_AAAA);
    check_eq("rmw_rd_cnt", 32'(n_c_rd - r0), 1);
    check_eq("rmw_wr_cnt", 32'(n_c_wr - w0), 1);
    dir_q.push_back(mk_req(32'h40, 1'b0, 4'hF, '0, 8'h3D));
    run_idle();

    // Drain: partial write must wait for three outstanding reads.
    a0 = n_up_acc; r0 = n_c_rd; w0 = n_c_wr;
    hold_resp = 1;
    for (int i = 0; i < 3; i++) dir_q.push_back(mk_req(32'(i * 4), 1'b0, 4'hF, '0, 8'(i)));
    dir_q.push_back(mk_req(32'h8, 1'b1, 4'h4, 32'h00C3_0000, 8'h10));
    dir_q.push_back(mk_req(32'h8, 1'b0, 4'hF, '0, 8'h11));
    repeat (10) cycle();
    check_eq("drain_acc", 32'(n_up_acc - a0), 4);
    check_eq("drain_rd", 32'(n_c_rd - r0), 3);
    check_eq("drain_in_q_ready", 32'(in_q_ready_o), 0);
    hold_resp = 0;
    run_idle();
    check_eq("drain_rd_total", 32'(n_c_rd - r0), 5);
    check_eq("drain_wr_total", 32'(n_c_wr - w0), 1);

    // Outstanding limit.
    a0 = n_up_acc;
    hold_resp = 1;
    for (int i = 0; i < 17; i++) dir_q.push_back(mk_req(32'(i * 4), 1'b0, 4'hF, '0, 8'(i + 32)));
    repeat (25) cycle();
    check_eq("sat_acc", 32'(n_up_acc - a0), 16);
    check_eq("sat_in_q_ready", 32'(in_q_ready_o), 0);
    check_eq("sat_out_q_valid", 32'(out_q_valid_o), 0);
    hold_resp = 0;
    run_idle();
    check_eq("sat_acc_total", 32'(n_up_acc - a0), 17);

    // Zero strobe and full strobe writes.
    r0 = n_c_rd; w0 = n_c_wr;
    dir_q.push_back(mk_req(32'h80, 1'b1, 4'h0, 32'hFFFF_FFFF, 8'h21));
    run_idle();
    check_eq("strb0_data", last_c_wr, init_word(32'h80));
    check_eq("strb0_rd", 32'(n_c_rd - r0), 1);
    r0 = n_c_rd;
    dir_q.push_back(mk_req(32'h84, 1'b1, 4'hF, 32'hCAFE_F00D, 8'h22));
    run_idle();
    check_eq("strbF_data", last_c_wr, 32'hCAFE_F00D);
    check_eq("strbF_no_rd", 32'(n_c_rd - r0), 0);
    check_eq("strb_wr_cnt", 32'(n_c_wr - w0), 2);

    // Reset while waiting for the RMW read response.
    hold_resp = 1; r0 = n_c_rd;
    dir_q.push_back(mk_req(32'h90, 1'b1, 4'h1, 32'h0000_00EE, 8'h31));
    tries = 0;
    while (n_c_rd == r0 && tries < 20) begin cycle(); tries++; end
    check_eq("rstrd_read_seen", 32'(n_c_rd - r0), 1);
    cycle();
    rst = 1'b1;
    in_q_valid_i = 0;
    out_p_valid_i = 1; out_p_data_i = init_word(32'h90); out_p_user_i = 8'h31;
    #1;
    check_eq("rstrd_in_p_valid", 32'(in_p_valid_o), 0);
    check_eq("rstrd_out_q_valid", 32'(out_q_valid_o), 0);
    @(posedge clk); #1;
    rst = 1'b0; out_p_valid_i = 0;
    cache_q.delete(); exp_q.delete(); pres = 0; up_pending = 0; hold_resp = 0;
    mem_r = mem_c;
    #1;
    check_eq("rstrd_idle_valid", 32'(out_q_valid_o), 0);
    dir_q.push_back(mk_req(32'h90, 1'b0, 4'hF, '0, 8'h32));
    dir_q.push_back(mk_req(32'h94, 1'b1, 4'h2, 32'h0000_5500, 8'h33));
    dir_q.push_back(mk_req(32'h94, 1'b0, 4'hF, '0, 8'h34));
    run_idle();

    // Random traffic.
    rand_mode = 1;
    repeat (4000) cycle();
    rand_mode = 0;
    run_idle();
    for (int i = 0; i < 16; i++) check_eq("mem_final", rd_c(32'(i * 4)), rd_r(32'(i * 4)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
